// File: rtl/next_ptr_table_if.sv
// Bus bundle for next_ptr_table: init control, one write port, NR packed read ports
// and the sticky address-error flag.
interface next_ptr_table_if #(
    parameter int PTR_W = 6,
    parameter int NR    = 2
);
    logic                  init_req;
    logic                  init_done;
    logic                  W0_en;
    logic [PTR_W-1:0]      W0_addr;
    logic [PTR_W-1:0]      W0_data;
    logic [NR-1:0]         R_en;
    logic [NR*PTR_W-1:0]   R_addr;
    logic [NR*PTR_W-1:0]   R_data;
    logic [NR-1:0]         R_valid;
    logic                  addr_err;
    logic                  addr_err_clr;

    modport master (
        output init_req, W0_en, W0_addr, W0_data, R_en, R_addr, addr_err_clr,
        input  init_done, R_data, R_valid, addr_err
    );

    modport slave (
        input  init_req, W0_en, W0_addr, W0_data, R_en, R_addr, addr_err_clr,
        output init_done, R_data, R_valid, addr_err
    );
endinterface

// File: rtl/next_ptr_table.sv
// DEPTH x PTR_W next-pointer table: one write port, NR registered read ports with
// write-to-read bypass, a chain-building init sequencer and sticky range checking.
module next_ptr_table #(
    parameter int DEPTH = 40,
    parameter int PTR_W = 6,
    parameter int NR    = 2
) (
    input logic              clock,
    input logic              reset,
    next_ptr_table_if.slave  bus
);
    localparam logic [PTR_W:0]   LIMIT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t              state, state_n;
    logic [PTR_W-1:0]    cnt, cnt_n;

    logic [PTR_W-1:0]    mem [DEPTH];
    logic                mem_we;
    logic [PTR_W-1:0]    mem_waddr;
    logic [PTR_W-1:0]    mem_wdata;

    logic                w_ok;
    logic                err_hit;
    logic [NR-1:0]       r_oor;
    logic [PTR_W-1:0]    rd_val [NR];

    logic [NR*PTR_W-1:0] r_data_q;
    logic [NR-1:0]       r_valid_q;
    logic                err_q;

    function automatic logic in_range(input logic [PTR_W-1:0] a);
        return {1'b0, a} < LIMIT;
    endfunction

    assign w_ok = in_range(bus.W0_addr);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        mem_we    = 1'b0;
        mem_waddr = bus.W0_addr;
        mem_wdata = bus.W0_data;
        case (state)
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt;
                mem_wdata = (cnt == LAST) ? '0 : cnt + 1'b1;
                if (bus.init_req) begin
                    cnt_n = '0;
                end else if (cnt == LAST) begin
                    state_n = READY;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            READY: begin
                mem_we = bus.W0_en & w_ok;
                if (bus.init_req) begin
                    state_n = INIT;
                    cnt_n   = '0;
                end
            end
            default: state_n = INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    // Out-of-range reads return zero; a same-cycle in-range write wins over the stored entry.
    always_comb begin
        r_oor   = '0;
        rd_val  = '{default: '0};
        err_hit = bus.W0_en & ~w_ok;
        for (int unsigned k = 0; k < NR; k++) begin
            r_oor[k] = ~in_range(bus.R_addr[k*PTR_W +: PTR_W]);
            if (r_oor[k])
                rd_val[k] = '0;
            else if (bus.W0_en && w_ok && bus.R_addr[k*PTR_W +: PTR_W] == bus.W0_addr)
                rd_val[k] = bus.W0_data;
            else
                rd_val[k] = mem[bus.R_addr[k*PTR_W +: PTR_W]];
            err_hit = err_hit | (bus.R_en[k] & r_oor[k]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data_q  <= '0;
            r_valid_q <= '0;
            err_q     <= 1'b0;
        end else if (state == READY) begin
            r_valid_q <= bus.R_en;
            for (int unsigned k = 0; k < NR; k++) begin
                if (bus.R_en[k])
                    r_data_q[k*PTR_W +: PTR_W] <= rd_val[k];
            end
            if (err_hit)
                err_q <= 1'b1;
            else if (bus.addr_err_clr)
                err_q <= 1'b0;
        end else begin
            r_valid_q <= '0;
        end
    end

    assign bus.init_done = (state == READY);
    assign bus.R_data    = r_data_q;
    assign bus.R_valid   = r_valid_q;
    assign bus.addr_err  = err_q;
endmodule

// File: tb/tb_next_ptr_table.sv
// Directed plus randomized checks of next_ptr_table against an array-based
// reference of the table contents, read results and sticky error flag.
module tb_next_ptr_table;
    localparam int DEPTH = 40;
    localparam int PTR_W = 6;
    localparam int NR    = 2;

    logic clock;
    logic reset;

    next_ptr_table_if #(.PTR_W(PTR_W), .NR(NR)) bus ();

    next_ptr_table #(.DEPTH(DEPTH), .PTR_W(PTR_W), .NR(NR)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int model  [DEPTH];
    int exp_rd [NR];
    int exp_err;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [PTR_W-1:0] rd(input int k);
        return bus.R_data[k*PTR_W +: PTR_W];
    endfunction

    task automatic reset_model();
        for (int i = 0; i < DEPTH; i++)
            model[i] = (i + 1) % DEPTH;
    endtask

    task automatic idle();
        bus.init_req     = 1'b0;
        bus.W0_en        = 1'b0;
        bus.W0_addr      = '0;
        bus.W0_data      = '0;
        bus.R_en         = '0;
        bus.R_addr       = '0;
        bus.addr_err_clr = 1'b0;
    endtask

    // One READY cycle: predict from the model, drive, clock, compare.
    task automatic step(input bit we, input int wa, input int wd, input bit [NR-1:0] re,
                        input int ra0, input int ra1, input bit clr);
        int ra [NR];
        bit oor;
        ra[0] = ra0;
        ra[1] = ra1;
        oor = we && (wa >= DEPTH);
        for (int k = 0; k < NR; k++) begin
            if (re[k]) begin
                if (ra[k] >= DEPTH) begin
                    exp_rd[k] = 0;
                    oor = 1'b1;
                end else if (we && wa == ra[k]) begin
                    exp_rd[k] = wd;
                end else begin
                    exp_rd[k] = model[ra[k]];
                end
            end
        end
        if (oor)
            exp_err = 1;
        else if (clr)
            exp_err = 0;
        if (we && wa < DEPTH)
            model[wa] = wd;

        bus.init_req     = 1'b0;
        bus.W0_en        = we;
        bus.W0_addr      = PTR_W'(wa);
        bus.W0_data      = PTR_W'(wd);
        bus.R_en         = re;
        bus.R_addr       = {PTR_W'(ra1), PTR_W'(ra0)};
        bus.addr_err_clr = clr;
        tick();
        for (int k = 0; k < NR; k++) begin
            chk($sformatf("rvalid%0d", k), 32'(bus.R_valid[k]), 32'(re[k]));
            chk($sformatf("rdata%0d", k), 32'(rd(k)), 32'(exp_rd[k]));
        end
        chk("addr_err", 32'(bus.addr_err), 32'(exp_err));
        chk("init_done_ready", 32'(bus.init_done), 32'd1);
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (bus.init_done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        bit we;
        int wa, ra0;

        reset = 1'b1;
        idle();
        reset_model();
        exp_rd  = '{0, 0};
        exp_err = 0;
        tick();
        tick();
        chk("rst_init_done", 32'(bus.init_done), 32'd0);
        chk("rst_rvalid", 32'(bus.R_valid), 32'd0);
        chk("rst_rdata", 32'(bus.R_data), 32'd0);
        chk("rst_addr_err", 32'(bus.addr_err), 32'd0);
        #2 reset = 1'b0;

        // Traffic during init must be ignored entirely.
        n = 0;
        while (bus.init_done !== 1'b1 && n < 100) begin
            bus.W0_en   = 1'b1;
            bus.W0_addr = PTR_W'($urandom);
            bus.W0_data = PTR_W'($urandom);
            bus.R_en    = '1;
            bus.R_addr  = (NR*PTR_W)'($urandom);
            tick();
            n++;
            chk("init_rvalid", 32'(bus.R_valid), 32'd0);
        end
        idle();
        chk("init_len", 32'(n), 32'd40);
        chk("init_addr_err", 32'(bus.addr_err), 32'd0);
        chk("init_rdata_hold", 32'(bus.R_data), 32'd0);

        step(0, 0, 0, 2'b01, 0, 0, 0);
        chk("rd_addr0", 32'(rd(0)), 32'd1);
        step(0, 0, 0, 2'b10, 0, 38, 0);
        chk("rd_addr38", 32'(rd(1)), 32'd39);
        step(0, 0, 0, 2'b11, 39, 39, 0);
        chk("rd_addr39_p0", 32'(rd(0)), 32'd0);
        chk("rd_addr39_p1", 32'(rd(1)), 32'd0);
        for (int i = 0; i < DEPTH; i++)
            step(0, 0, 0, 2'b11, i, DEPTH - 1 - i, 0);

        step(1, 5, 17, 2'b00, 0, 0, 0);
        step(0, 0, 0, 2'b11, 5, 5, 0);
        chk("wr5_p0", 32'(rd(0)), 32'd17);
        chk("wr5_p1", 32'(rd(1)), 32'd17);

        step(1, 12, 33, 2'b01, 12, 0, 0);
        chk("bypass12", 32'(rd(0)), 32'd33);
        step(0, 0, 0, 2'b01, 12, 0, 0);
        chk("after_bypass12", 32'(rd(0)), 32'd33);

        step(0, 0, 0, 2'b01, 45, 0, 0);
        chk("oor_rdata", 32'(rd(0)), 32'd0);
        chk("oor_rvalid", 32'(bus.R_valid[0]), 32'd1);
        chk("oor_err", 32'(bus.addr_err), 32'd1);
        step(0, 0, 0, 2'b00, 0, 0, 1);
        chk("clr_err", 32'(bus.addr_err), 32'd0);
        step(1, 50, 9, 2'b00, 0, 0, 1);
        chk("set_over_clr", 32'(bus.addr_err), 32'd1);
        step(0, 0, 0, 2'b00, 0, 0, 1);
        step(0, 0, 0, 2'b00, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            we  = 1'($urandom_range(0, 1));
            wa  = int'($urandom_range(0, 47));
            ra0 = ($urandom_range(0, 1) == 0) ? wa : int'($urandom_range(0, 47));
            step(we, wa, int'($urandom_range(0, 63)), 2'($urandom), ra0,
                 int'($urandom_range(0, 47)), $urandom_range(0, 7) == 0);
        end

        step(1, 3, 7, 2'b00, 0, 0, 0);
        step(0, 0, 0, 2'b01, 3, 0, 0);
        chk("ovw3", 32'(rd(0)), 32'd7);
        idle();
        bus.init_req = 1'b1;
        tick();
        bus.init_req = 1'b0;
        chk("reinit_low", 32'(bus.init_done), 32'd0);
        wait_init(n);
        chk("reinit_len", 32'(n), 32'd40);
        chk("reinit_rdata_hold", 32'(rd(0)), 32'd7);
        reset_model();
        step(0, 0, 0, 2'b01, 3, 0, 0);
        chk("reinit_addr3", 32'(rd(0)), 32'd4);

        bus.init_req = 1'b1;
        tick();
        bus.init_req = 1'b0;
        repeat (20) tick();
        reset = 1'b1;
        #1;
        chk("midinit_rst_done", 32'(bus.init_done), 32'd0);
        chk("midinit_rst_rdata", 32'(bus.R_data), 32'd0);
        chk("midinit_rst_err", 32'(bus.addr_err), 32'd0);
        exp_rd  = '{0, 0};
        exp_err = 0;
        tick();
        #2 reset = 1'b0;
        wait_init(n);
        chk("rst_reinit_len", 32'(n), 32'd40);
        reset_model();
        for (int i = 0; i < DEPTH; i++)
            step(0, 0, 0, 2'b11, i, (i * 7) % DEPTH, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
